// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller
//   Owns the fetch PC, keeps at most one read outstanding to the instruction
//   memory, and buffers returned words in a 2-entry queue for decode.
//   Redirects from execute flush the queue and retarget the PC.
//   Optional: define IMEM_FETCH_BOUND_CHECK_EN to replace fetches outside the
//   text segment with a NOP and raise a sticky fetch_fault.
module imem_fetch_controller #(
   parameter logic [31:0] TEXT_BASE  = 32'h00400000,
   parameter int          TEXT_WORDS = 18,
   parameter int          QDEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        fetch_fault
);

   // Queue indexing below relies on exactly two entries.
   generate
      if (QDEPTH != 2 || TEXT_WORDS < 1) begin : g_cfg_check
         $error("imem_fetch_controller: QDEPTH must be 2 and TEXT_WORDS >= 1");
      end
   endgenerate

   localparam logic [0:0] S_ISSUE = 1'b0;
   localparam logic [0:0] S_WAIT  = 1'b1;

   logic [0:0]  state;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic        discard;

   logic [31:0] q_pc  [0:1];
   logic [31:0] q_ins [0:1];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;

   logic        in_text;
   logic        can_issue;
   logic        issue_mem;
   logic        nop_push;
   logic        resp;
   logic        push;
   logic        pop;
   logic [31:0] push_pc;
   logic [31:0] push_ins;
   logic [31:0] redir_tgt;

`ifdef IMEM_FETCH_BOUND_CHECK_EN
   localparam logic [31:0] TEXT_END = TEXT_BASE + 32'(4 * TEXT_WORDS);
   assign in_text = (pc >= TEXT_BASE) && (pc < TEXT_END);
`else
   assign in_text = 1'b1;
`endif

   assign redir_tgt = {redirect_pc[31:2], 2'b00};

   // The outstanding slot is implicit: requests only leave ISSUE, so in ISSUE
   // nothing is in flight and a free queue entry is enough to issue.
   assign can_issue = (state == S_ISSUE) && (int'(count) < QDEPTH) && !redirect_valid;
   assign issue_mem = can_issue && in_text;
   assign nop_push  = can_issue && !in_text;
   assign resp      = (state == S_WAIT) && imem_valid;

   // Gated by rst_n so the strobe is quiet while reset is held.
   assign imem_req  = issue_mem && rst_n;
   assign imem_addr = (state == S_WAIT) ? req_pc : pc;

   // Words arriving with a redirect or while a discard is pending are dropped.
   assign push     = (resp && !discard && !redirect_valid) || nop_push;
   assign push_pc  = nop_push ? pc : req_pc;
   assign push_ins = nop_push ? 32'h00000000 : imem_rdata;

   assign instr_valid = (count != 2'd0);
   assign pop         = instr_valid && instr_ready;
   assign instr_out   = instr_valid ? q_ins[rd_ptr] : 32'h00000000;
   assign pc_out      = instr_valid ? q_pc[rd_ptr]  : 32'h00000000;

   // Fetch FSM: PC, request bookkeeping and stale-response discard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_ISSUE;
         pc      <= TEXT_BASE;
         req_pc  <= TEXT_BASE;
         discard <= 1'b0;
      end else begin
         case (state)
            S_ISSUE: begin
               if (redirect_valid) begin
                  pc <= redir_tgt;
               end else if (issue_mem) begin
                  req_pc <= pc;
                  pc     <= pc + 32'd4;
                  state  <= S_WAIT;
               end else if (nop_push) begin
                  pc <= pc + 32'd4;
               end
            end
            default: begin
               if (redirect_valid) begin
                  pc <= redir_tgt;
                  if (imem_valid) begin
                     state   <= S_ISSUE;
                     discard <= 1'b0;
                  end else begin
                     discard <= 1'b1;
                  end
               end else if (imem_valid) begin
                  state   <= S_ISSUE;
                  discard <= 1'b0;
               end
            end
         endcase
      end
   end

   // Two-entry fetch queue; a redirect flushes it after any same-cycle pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_pc[0]  <= 32'h0;
         q_pc[1]  <= 32'h0;
         q_ins[0] <= 32'h0;
         q_ins[1] <= 32'h0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         count    <= 2'd0;
      end else if (redirect_valid) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]  <= push_pc;
            q_ins[wr_ptr] <= push_ins;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

`ifdef IMEM_FETCH_BOUND_CHECK_EN
   // Sticky out-of-text fetch flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        fetch_fault <= 1'b0;
      else if (nop_push) fetch_fault <= 1'b1;
   end
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Self-checking bench for imem_fetch_controller: a behavioural memory with
// programmable latency, a stream scoreboard of expected fetch addresses and
// delivered {pc, instr} pairs, and directed redirect/reset scenarios.
module tb_imem_fetch_controller;
   localparam logic [31:0] TBASE = 32'h00400000;
   localparam int          TWORDS = 18;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        fetch_fault;

   imem_fetch_controller #(.TEXT_BASE(TBASE), .TEXT_WORDS(TWORDS), .QDEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .pc_out(pc_out), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int nreq     = 0;
   int ndel     = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == TBASE)              return 32'h012a4020;
      else if (a == TBASE + 32'd4) return 32'h02328022;
      else                         return {16'hC0DE, a[15:0]};
   endfunction

   function automatic bit in_text(input logic [31:0] a);
`ifdef IMEM_FETCH_BOUND_CHECK_EN
      return (a >= TBASE) && (a < TBASE + 32'(4 * TWORDS));
`else
      return (a == a);
`endif
   endfunction

   // ---------------- memory model ----------------
   int          lat  = 1;
   int          mcnt = 0;
   logic [31:0] maddr = 32'h0;

   always @(negedge clk) begin
      if (rst_n && imem_req) begin
         mcnt  = lat;
         maddr = imem_addr;
      end
   end

   always @(posedge clk) begin
      #1;
      imem_valid = 1'b0;
      imem_rdata = 32'hxxxxxxxx;
      if (!rst_n) begin
         mcnt = 0;
      end else if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(maddr);
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q[$];
   logic [31:0] addr_q[$];

   task automatic refill(input logic [31:0] start);
      logic [31:0] p;
      exp_q.delete();
      addr_q.delete();
      for (int i = 0; i < 40; i++) begin
         p = start + 32'(4 * i);
         if (in_text(p)) begin
            exp_q.push_back({p, mem_word(p)});
            addr_q.push_back(p);
         end else begin
            exp_q.push_back({p, 32'h00000000});
         end
      end
   endtask

   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst_n) begin
         refill(TBASE);
      end else begin
         if (imem_req) begin
            nreq++;
            if (addr_q.size() == 0) chk("addr_q_empty", 32'd0, 32'd1);
            else                    chk("imem_addr", imem_addr, addr_q.pop_front());
         end
         if (instr_valid && instr_ready) begin
            ndel++;
            if (exp_q.size() == 0) chk("exp_q_empty", 32'd0, 32'd1);
            else begin
               e = exp_q.pop_front();
               chk("pc_out", pc_out, e[63:32]);
               chk("instr_out", instr_out, e[31:0]);
            end
         end
         if (redirect_valid) refill({redirect_pc[31:2], 2'b00});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_del(input int n, input string tag);
      int t = 0;
      while (ndel < n && t < 300) begin cyc(); t++; end
      chk(tag, 32'(ndel >= n), 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int t = 0;
      while (!imem_req && t < 100) begin cyc(); t++; end
      chk(tag, {31'd0, imem_req}, 32'd1);
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      cyc();
      redirect_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
      chk({tag, "_addr"},  imem_addr,            TBASE);
      chk({tag, "_vld"},   {31'd0, instr_valid}, 32'd0);
      chk({tag, "_instr"}, instr_out,            32'd0);
      chk({tag, "_pc"},    pc_out,               32'd0);
      chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
   endtask

   initial begin
      int n0, d0, t;
      rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (3) cyc();
      chk_reset_outputs("reset");

      // Basic stream, latency and throughput with a 1-cycle memory.
      rst_n = 1'b1;
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      cyc();
      chk("lat_vld_early", {31'd0, instr_valid}, 32'd0);
      cyc();
      chk("lat_vld", {31'd0, instr_valid}, 32'd1);
      chk("lat_pc", pc_out, TBASE);
      chk("lat_instr", instr_out, 32'h012a4020);
      wait_del(4, "stream_del");
      n0 = nreq;
      repeat (10) cyc();
      chk("throughput_reqs", 32'(nreq - n0), 32'd5);

      // Decoder stall: exactly two words fetched then issue stops.
      instr_ready = 1'b0;
      n0 = nreq;
      pulse_redirect(TBASE + 32'h20);
      repeat (10) cyc();
      chk("stall_reqs", 32'(nreq - n0), 32'd2);
      chk("stall_vld", {31'd0, instr_valid}, 32'd1);
      chk("stall_req_low", {31'd0, imem_req}, 32'd0);
      d0 = ndel;
      instr_ready = 1'b1;
      wait_del(d0 + 4, "drain_del");

      // Redirect while WAITing on a 3-cycle memory.
      lat = 3;
      wait_req("slow_req_seen");
      cyc();
      pulse_redirect(32'h00400010);
      wait_req("redir_req_seen");
      chk("redir_addr", imem_addr, 32'h00400010);
      t = 0;
      while (!instr_valid && t < 50) begin cyc(); t++; end
      chk("redir_first_pc", pc_out, 32'h00400010);

      // Back-to-back redirects in WAIT: the last target wins.
      wait_req("b2b_req_seen");
      cyc();
      pulse_redirect(32'h00400030);
      pulse_redirect(32'h00400009);
      t = 0;
      while (!instr_valid && t < 50) begin cyc(); t++; end
      chk("b2b_first_pc", pc_out, 32'h00400008);
      chk("b2b_first_instr", instr_out, mem_word(32'h00400008));

      // Redirect coincident with a response and a queue pop.
      lat = 1;
      instr_ready = 1'b0;
      pulse_redirect(32'h00400040);
      t = 0;
      while (!instr_valid && t < 50) begin cyc(); t++; end
      chk("coin_vld_seen", {31'd0, instr_valid}, 32'd1);
      t = 0;
      while (!imem_valid && t < 50) begin cyc(); t++; end
      chk("coin_rsp_seen", {31'd0, imem_valid}, 32'd1);
      d0 = ndel;
      instr_ready = 1'b1;
      pulse_redirect(32'h00400024);
      chk("coin_popped", 32'(ndel - d0), 32'd1);
      chk("coin_flushed", {31'd0, instr_valid}, 32'd0);
      wait_del(d0 + 3, "coin_del");

      // Reset in the middle of WAIT.
      lat = 3;
      wait_req("rst_req_seen");
      cyc();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      repeat (3) cyc();
      chk_reset_outputs("midrst_hold");
      rst_n = 1'b1;
      #1;
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, TBASE);
      lat = 1;
      d0 = ndel;
      wait_del(d0 + 3, "post_rst_del");

`ifdef IMEM_FETCH_BOUND_CHECK_EN
      // Out-of-text fetch becomes a NOP and raises the sticky fault.
      instr_ready = 1'b0;
      pulse_redirect(32'h003FFFFC);
      t = 0;
      while (!instr_valid && t < 50) begin cyc(); t++; end
      chk("bound_pc", pc_out, 32'h003FFFFC);
      chk("bound_instr", instr_out, 32'h00000000);
      chk("bound_fault", {31'd0, fetch_fault}, 32'd1);
      d0 = ndel;
      instr_ready = 1'b1;
      wait_del(d0 + 3, "bound_del");
      chk("bound_fault_sticky", {31'd0, fetch_fault}, 32'd1);
`endif

      repeat (4) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
